// File: rtl/ss_display_arbiter.sv
// ss_display_arbiter: shares an 8-digit 7-segment display between two requesters at scan-frame boundaries
module ss_display_arbiter #(
    parameter int REFRESH_DIV = 50000,
    parameter int HOLD_FRAMES = 100
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req0,
    input  logic [31:0] bcd0,
    input  logic [7:0]  dots0,
    output logic        ack0,
    input  logic        req1,
    input  logic [31:0] bcd1,
    input  logic [7:0]  dots1,
    output logic        ack1,
    output logic        clk_enable,
    output logic [31:0] bcd,
    output logic [7:0]  dots,
    output logic [1:0]  owner
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int HW = HOLD_FRAMES < 2 ? 1 : $clog2(HOLD_FRAMES);
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES > 0 ? HOLD_FRAMES - 1 : 0);

    typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;

    state_t        state, state_next;
    logic [PW-1:0] pre;
    logic [2:0]    digit;
    logic [HW-1:0] hold, hold_next;
    logic          last_grant;
    logic          frame_end, arb_open, grant, sel1;

    // refresh prescaler and registered digit-advance strobe
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pre        <= '0;
            clk_enable <= 1'b0;
        end else begin
            pre        <= pre == PRE_LAST ? '0 : pre + 1'b1;
            clk_enable <= pre == PRE_LAST;
        end
    end

    // nominal scan position, used only to find frame boundaries
    always_ff @(posedge clk) begin
        if (!resetn)
            digit <= '0;
        else if (clk_enable)
            digit <= digit + 1'b1;
    end

    // arbitration window, round-robin choice and next FSM state
    always_comb begin
        frame_end  = clk_enable && digit == 3'd7;
        arb_open   = state != HOLD || hold == HOLD_LAST;
        grant      = frame_end && arb_open && (req0 || req1);
        sel1       = req1 && (!req0 || !last_grant);
        state_next = grant ? (HOLD_FRAMES == 0 ? OPEN : HOLD)
                   : (frame_end && state == HOLD && hold == HOLD_LAST) ? OPEN : state;
        hold_next  = grant ? '0 : (frame_end && state == HOLD) ? hold + 1'b1 : hold;
    end

    // FSM state and hold-frame counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            hold  <= '0;
        end else begin
            state <= state_next;
            hold  <= hold_next;
        end
    end

    // latch the granted port's content and pulse its ack in the same cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            bcd        <= '0;
            dots       <= '0;
            owner      <= 2'd0;
            last_grant <= 1'b1;
        end else begin
            ack0 <= grant && !sel1;
            ack1 <= grant && sel1;
            if (grant) begin
                bcd        <= sel1 ? bcd1 : bcd0;
                dots       <= sel1 ? dots1 : dots0;
                owner      <= sel1 ? 2'd2 : 2'd1;
                last_grant <= sel1;
            end
        end
    end
endmodule

// File: tb/tb_ss_display_arbiter.sv
// tb_ss_display_arbiter: directed checks of prescaler, grants, hold and reset behaviour
module tb_ss_display_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        req0, req1;
    logic [31:0] bcd0, bcd1;
    logic [7:0]  dots0, dots1;
    logic        ack0, ack1, clk_enable;
    logic [31:0] bcd;
    logic [7:0]  dots;
    logic [1:0]  owner;
    logic        z_ack0, z_ack1, z_ce;
    logic [31:0] z_bcd;
    logic [7:0]  z_dots;
    logic [1:0]  z_owner;
    int          total = 0;
    int          bad = 0;
    int          t = 0;

    ss_display_arbiter #(.REFRESH_DIV(4), .HOLD_FRAMES(2)) dut (
        .clk(clk), .resetn(resetn),
        .req0(req0), .bcd0(bcd0), .dots0(dots0), .ack0(ack0),
        .req1(req1), .bcd1(bcd1), .dots1(dots1), .ack1(ack1),
        .clk_enable(clk_enable), .bcd(bcd), .dots(dots), .owner(owner)
    );

    ss_display_arbiter #(.REFRESH_DIV(4), .HOLD_FRAMES(0)) dut0 (
        .clk(clk), .resetn(resetn),
        .req0(1'b1), .bcd0(32'h0000_AAAA), .dots0(8'h0A), .ack0(z_ack0),
        .req1(1'b1), .bcd1(32'h0000_BBBB), .dots1(8'h0B), .ack1(z_ack1),
        .clk_enable(z_ce), .bcd(z_bcd), .dots(z_dots), .owner(z_owner)
    );

    always #5 clk = ~clk;

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
        t += n;
    endtask

    task automatic upto(input int n);
        adv(n - t);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        bcd0 = 32'h0000_1234; dots0 = 8'h04;
        bcd1 = 32'h0000_5678; dots1 = 8'h80;
        adv(3);
        chk("rst_ce", {31'd0, clk_enable}, 32'd0);
        chk("rst_ack", {30'd0, ack0, ack1}, 32'd0);
        chk("rst_bcd", bcd, 32'd0);
        chk("rst_dots", {24'd0, dots}, 32'd0);
        chk("rst_owner", {30'd0, owner}, 32'd0);
        resetn = 1'b1; req1 = 1'b0; t = 0;
        upto(3);  chk("pre_3", {31'd0, clk_enable}, 32'd0);
        upto(4);  chk("pre_4", {31'd0, clk_enable}, 32'd1);
        upto(5);  chk("pre_5", {31'd0, clk_enable}, 32'd0);
        upto(8);  chk("pre_8", {31'd0, clk_enable}, 32'd1);
        upto(32);
        chk("single_pre_ack", {31'd0, ack0}, 32'd0);
        chk("single_pre_bcd", bcd, 32'd0);
        upto(33);
        chk("single_ack0", {31'd0, ack0}, 32'd1);
        chk("single_ack1", {31'd0, ack1}, 32'd0);
        chk("single_bcd", bcd, 32'h0000_1234);
        chk("single_dots", {24'd0, dots}, 32'h04);
        chk("single_owner", {30'd0, owner}, 32'd1);
        req0 = 1'b0;
        upto(34);
        chk("single_ack_width", {31'd0, ack0}, 32'd0);
        req1 = 1'b1;
        upto(65);
        chk("hold_no_ack1", {31'd0, ack1}, 32'd0);
        chk("hold_bcd", bcd, 32'h0000_1234);
        chk("hold_owner", {30'd0, owner}, 32'd1);
        upto(96);
        chk("hold_end_pre", {31'd0, ack1}, 32'd0);
        upto(97);
        chk("hold_ack1", {30'd0, ack0, ack1}, 32'd1);
        chk("hold_owner2", {30'd0, owner}, 32'd2);
        chk("hold_bcd2", bcd, 32'h0000_5678);
        chk("hold_dots2", {24'd0, dots}, 32'h80);
        req1 = 1'b0;
        upto(100);
        req0 = 1'b1; bcd0 = 32'h0000_9999; dots0 = 8'h01; resetn = 1'b0;
        adv(1);
        chk("midrst_owner", {30'd0, owner}, 32'd0);
        chk("midrst_bcd", bcd, 32'd0);
        chk("midrst_dots", {24'd0, dots}, 32'd0);
        chk("midrst_ack", {30'd0, ack0, ack1}, 32'd0);
        chk("midrst_ce", {31'd0, clk_enable}, 32'd0);
        resetn = 1'b1; t = 0;
        upto(32);
        chk("midrst_wait", {30'd0, ack0, ack1}, 32'd0);
        upto(33);
        chk("midrst_ack0", {30'd0, ack0, ack1}, 32'd2);
        chk("midrst_bcd2", bcd, 32'h0000_9999);
        chk("midrst_owner2", {30'd0, owner}, 32'd1);
        resetn = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        bcd0 = 32'h0000_AAAA; bcd1 = 32'h0000_BBBB;
        adv(2);
        resetn = 1'b1; t = 0;
        upto(33);
        chk("tie_ack_1", {30'd0, ack0, ack1}, 32'd2);
        chk("tie_owner_1", {30'd0, owner}, 32'd1);
        chk("z_owner_1", {30'd0, z_owner}, 32'd1);
        chk("z_ack_1", {30'd0, z_ack0, z_ack1}, 32'd2);
        upto(34);
        chk("z_ack_gap", {30'd0, z_ack0, z_ack1}, 32'd0);
        upto(65);
        chk("tie_owner_65", {30'd0, owner}, 32'd1);
        chk("z_owner_2", {30'd0, z_owner}, 32'd2);
        chk("z_ack_2", {30'd0, z_ack0, z_ack1}, 32'd1);
        chk("z_bcd_2", z_bcd, 32'h0000_BBBB);
        upto(96);
        chk("tie_owner_96", {30'd0, owner}, 32'd1);
        upto(97);
        chk("tie_ack_2", {30'd0, ack0, ack1}, 32'd1);
        chk("tie_owner_2", {30'd0, owner}, 32'd2);
        chk("tie_bcd_2", bcd, 32'h0000_BBBB);
        chk("z_owner_3", {30'd0, z_owner}, 32'd1);
        upto(129);
        chk("z_owner_4", {30'd0, z_owner}, 32'd2);
        upto(160);
        chk("tie_owner_160", {30'd0, owner}, 32'd2);
        upto(161);
        chk("tie_ack_3", {30'd0, ack0, ack1}, 32'd2);
        chk("tie_owner_3", {30'd0, owner}, 32'd1);
        chk("tie_bcd_3", bcd, 32'h0000_AAAA);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
